// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: fetch, load/store and memory bus bundle.
// slave = arbiter side, master = pipeline plus memory side.
//
// Fetch    : if_req, if_addr -> if_rdata, if_valid, if_stall
// Data     : mem_req, mem_we, mem_addr, mem_wdata
//            -> mem_rdata, mem_valid, mem_stall
// Memory   : ram_en, ram_we, ram_addr, ram_wdata <- ram_rdata
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       if_rdata;
    logic              if_valid;
    logic              if_stall;
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_valid;
    logic              mem_stall;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_valid, if_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_valid, mem_stall,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_valid, if_stall,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_valid, mem_stall,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port word memory between
// the IF fetch port and the MEM load/store port.
//
// Ports:
//   clk, rst : clock (rising edge), async active-high reset
//   bus      : unified_mem_arbiter_if.slave
//              fetch  : if_req/if_addr in, if_rdata/if_valid/if_stall out
//              data   : mem_req/we/addr/wdata in,
//                       mem_rdata/mem_valid/mem_stall out
//              memory : ram_en/we/addr/wdata out, ram_rdata in
//
// Data has priority; after MAX_STREAK back-to-back data grants
// with fetch waiting, fetch is granted once.
module unified_mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int LAT        = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    unified_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [2:0] LAT_M1 = 3'(LAT - 1);
    localparam logic [3:0] MAX_S  = 4'(MAX_STREAK);

    state_t            state;
    logic              own_fetch;
    logic              cmd_we;
    logic [2:0]        lat_cnt;
    logic [3:0]        streak;

    logic              ram_en_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [31:0]       ram_wdata_q;
    logic              if_valid_q;
    logic              mem_valid_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       mem_rdata_q;

    logic              grant_d;
    logic              grant_f;

    // Fetch only wins a contested cycle once the streak is exhausted.
    assign grant_d = bus.mem_req &
                     ~(bus.if_req & (streak == MAX_S));
    assign grant_f = ~grant_d & bus.if_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            own_fetch   <= 1'b0;
            cmd_we      <= 1'b0;
            lat_cnt     <= '0;
            streak      <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            // Strobes and completion pulses last a single cycle.
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        grant_d: begin
                            own_fetch   <= 1'b0;
                            cmd_we      <= bus.mem_we;
                            ram_en_q    <= 1'b1;
                            ram_we_q    <= bus.mem_we;
                            ram_addr_q  <= bus.mem_addr[ADDR_W+1:2];
                            ram_wdata_q <= bus.mem_wdata;
                            if (!bus.if_req)
                                streak <= '0;
                            else if (streak != MAX_S)
                                streak <= streak + 4'd1;
                            state       <= ISSUE;
                        end
                        grant_f: begin
                            own_fetch   <= 1'b1;
                            cmd_we      <= 1'b0;
                            ram_en_q    <= 1'b1;
                            ram_we_q    <= 1'b0;
                            ram_addr_q  <= bus.if_addr[ADDR_W+1:2];
                            ram_wdata_q <= '0;
                            streak      <= '0;
                            state       <= ISSUE;
                        end
                        default: ;
                    endcase
                end
                ISSUE: begin
                    if (cmd_we) begin
                        mem_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        lat_cnt <= LAT_M1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // lat_cnt hits 0 in the cycle ISSUE+LAT,
                    // when ram_rdata is valid.
                    if (lat_cnt == 3'd0) begin
                        if (own_fetch) begin
                            if_rdata_q <= bus.ram_rdata;
                            if_valid_q <= 1'b1;
                        end else begin
                            mem_rdata_q <= bus.ram_rdata;
                            mem_valid_q <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.if_stall  = bus.if_req & ~if_valid_q;
    assign bus.mem_stall = bus.mem_req & ~mem_valid_q;

    // Byte-offset and out-of-range address bits are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2],
                                bus.if_addr[1:0],
                                bus.mem_addr[31:ADDR_W+2],
                                bus.mem_addr[1:0]};
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: random requesters and a latency-LAT
// memory, checked against a transaction-level arbitration model.
module tb_unified_mem_arbiter;
    localparam int ADDR_W = 10;
    localparam int LAT    = 3;
    localparam int MAXS   = 4;
    localparam int NC     = 8192;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic clk;
    logic rst;

    unified_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    unified_mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .LAT       (LAT),
        .MAX_STREAK(MAXS)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: write on strobe, read data appears LAT cycles later.
    // Cycles without a read shift in junk to expose bad sampling.
    bit   [31:0] ram [1024];
    logic [31:0] rd_pipe [LAT];
    always @(posedge clk) begin
        if (bus.ram_en && bus.ram_we)
            ram[bus.ram_addr] <= bus.ram_wdata;
        rd_pipe[0] <= bus.ram_en ? ram[bus.ram_addr] : $urandom;
        for (int i = 1; i < LAT; i++)
            rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.ram_rdata = rd_pipe[LAT-1];

    // Reference model: expected events per absolute cycle.
    bit          exp_en   [NC];
    bit          exp_we   [NC];
    bit   [9:0]  exp_addr [NC];
    bit   [31:0] exp_wd   [NC];
    bit          exp_ifv  [NC];
    bit          exp_memv [NC];
    bit          exp_ld   [NC];
    bit   [31:0] exp_ifd  [NC];
    bit   [31:0] exp_memd [NC];
    bit   [31:0] mdl_mem  [1024];

    int          c;
    int          free_at;
    int          streak_m;
    bit   [31:0] last_if;
    int          n_tests;
    int          n_fail;

    req_t        fq[$];
    req_t        dq[$];
    bit          owner_q[$];
    bit          rnd_mode;
    bit          log_on;
    bit          f_pend, d_pend, f_gnt, d_gnt;
    bit          saw_ifv, saw_memv;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h cycle %0d",
                     tag, got, exp, c);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ram_en"},    bus.ram_en,    0);
        check({tag, "_ram_we"},    bus.ram_we,    0);
        check({tag, "_if_valid"},  bus.if_valid,  0);
        check({tag, "_mem_valid"}, bus.mem_valid, 0);
        check({tag, "_if_rdata"},  bus.if_rdata,  0);
        check({tag, "_mem_rdata"}, bus.mem_rdata, 0);
        check({tag, "_ram_addr"},  bus.ram_addr,  0);
        check({tag, "_ram_wdata"}, bus.ram_wdata, 0);
        check({tag, "_if_stall"},  bus.if_stall,  0);
        check({tag, "_mem_stall"}, bus.mem_stall, 0);
    endtask

    task automatic clear_from(input int from);
        for (int i = from; i < NC; i++) begin
            exp_en[i]   = 0;
            exp_ifv[i]  = 0;
            exp_memv[i] = 0;
        end
    endtask

    // Requesters: hold a request until its valid is seen, then
    // take the next one. Granted fields are scrambled on purpose.
    task automatic drive();
        req_t r;
        if (f_pend && saw_ifv) begin f_pend = 0; f_gnt = 0; end
        if (d_pend && saw_memv) begin d_pend = 0; d_gnt = 0; end
        if (!f_pend) begin
            if (fq.size() > 0) begin
                r = fq.pop_front();
                f_pend = 1;
                bus.if_addr = r.addr;
            end else if (rnd_mode && $urandom_range(99) < 50) begin
                f_pend = 1;
                bus.if_addr = $urandom & 32'hFFFF_F03F;
            end else begin
                bus.if_addr = $urandom;
            end
        end else if (f_gnt) begin
            bus.if_addr = $urandom;
        end
        if (!d_pend) begin
            if (dq.size() > 0) begin
                r = dq.pop_front();
                d_pend = 1;
                bus.mem_we    = r.we;
                bus.mem_addr  = r.addr;
                bus.mem_wdata = r.wdata;
            end else if (rnd_mode && $urandom_range(99) < 60) begin
                d_pend = 1;
                bus.mem_we    = $urandom_range(1);
                bus.mem_addr  = $urandom & 32'hFFFF_F03F;
                bus.mem_wdata = $urandom;
            end else begin
                bus.mem_we    = $urandom_range(1);
                bus.mem_addr  = $urandom;
                bus.mem_wdata = $urandom;
            end
        end else if (d_gnt) begin
            bus.mem_we    = $urandom_range(1);
            bus.mem_addr  = $urandom;
            bus.mem_wdata = $urandom;
        end
        bus.if_req  = f_pend;
        bus.mem_req = d_pend;
    endtask

    task automatic sample();
        bit       td;
        int       v;
        bit [9:0] a;
        check("ram_en", bus.ram_en, exp_en[c]);
        if (exp_en[c]) begin
            check("ram_we", bus.ram_we, exp_we[c]);
            check("ram_addr", bus.ram_addr, exp_addr[c]);
            if (exp_we[c])
                check("ram_wdata", bus.ram_wdata, exp_wd[c]);
        end
        check("if_valid", bus.if_valid, exp_ifv[c]);
        check("mem_valid", bus.mem_valid, exp_memv[c]);
        if (exp_ifv[c]) last_if = exp_ifd[c];
        check("if_rdata", bus.if_rdata, last_if);
        if (exp_memv[c] && exp_ld[c])
            check("mem_rdata", bus.mem_rdata, exp_memd[c]);
        check("if_stall", bus.if_stall,
              bus.if_req & ~exp_ifv[c]);
        check("mem_stall", bus.mem_stall,
              bus.mem_req & ~exp_memv[c]);
        if (log_on && bus.ram_en)
            owner_q.push_back(bus.ram_addr < 10'h200);
        saw_ifv  = bus.if_valid;
        saw_memv = bus.mem_valid;
        // Arbitration decision for this idle cycle.
        if (c >= free_at && (bus.mem_req || bus.if_req)) begin
            td = bus.mem_req &&
                 !(bus.if_req && streak_m == MAXS);
            if (td && bus.if_req)
                streak_m = (streak_m < MAXS) ? streak_m + 1 : MAXS;
            else
                streak_m = 0;
            a = td ? bus.mem_addr[11:2] : bus.if_addr[11:2];
            exp_en[c+1]   = 1;
            exp_we[c+1]   = td && bus.mem_we;
            exp_addr[c+1] = a;
            exp_wd[c+1]   = bus.mem_wdata;
            if (td && bus.mem_we) begin
                v = c + 2;
                mdl_mem[a]  = bus.mem_wdata;
                exp_memv[v] = 1;
                exp_ld[v]   = 0;
            end else begin
                v = c + LAT + 2;
                if (td) begin
                    exp_memv[v] = 1;
                    exp_ld[v]   = 1;
                    exp_memd[v] = mdl_mem[a];
                end else begin
                    exp_ifv[v] = 1;
                    exp_ifd[v] = mdl_mem[a];
                end
            end
            free_at = v + 1;
            if (td) d_gnt = 1;
            else    f_gnt = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        c++;
        #1;
        drive();
        @(negedge clk);
        sample();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bit [9:0] pat;
        int       g;
        int       nmv;
        rst = 1'b1;
        bus.if_req = 0; bus.if_addr = 0;
        bus.mem_req = 0; bus.mem_we = 0;
        bus.mem_addr = 0; bus.mem_wdata = 0;
        n_tests = 0; n_fail = 0;
        c = -1; free_at = 0; streak_m = 0; last_if = 0;
        clear_from(0);
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Seed an instruction word, then fetch it.
        dq.push_back('{1'b1, 32'h0000_0010, 32'h0050_0093});
        run(12);
        fq.push_back('{1'b0, 32'h0000_0010, 32'h0});
        run(10);
        check("fetch_rdata", bus.if_rdata, 32'h0050_0093);

        // Store then load the same word.
        dq.push_back('{1'b1, 32'h0000_0040, 32'hDEAD_BEEF});
        dq.push_back('{1'b0, 32'h0000_0040, 32'h0});
        run(20);
        check("load_rdata", bus.mem_rdata, 32'hDEAD_BEEF);

        // Both ports busy: expect D,D,D,D,F,D,D,D,D,F.
        log_on = 1;
        for (int i = 0; i < 10; i++)
            dq.push_back('{1'b0, 32'h800 + 4 * i, 32'h0});
        for (int i = 0; i < 3; i++)
            fq.push_back('{1'b0, 32'h400 + 4 * i, 32'h0});
        run(100);
        log_on = 0;
        check("grant_cnt", owner_q.size(), 13);
        pat = 10'b10000_10000;
        for (int i = 0; i < 10; i++)
            if (i < owner_q.size())
                check("grant_seq", owner_q[i], pat[i]);

        rnd_mode = 1;
        run(3000);
        rnd_mode = 0;
        run(40);

        // Reset while a fetch sits in WAIT.
        fq.push_back('{1'b0, 32'h0000_0010, 32'h0});
        g = 0;
        while (!f_gnt && g < 20) begin step(); g++; end
        check("fetch_grant", f_gnt, 1);
        step();
        step();
        #2;
        rst = 1'b1;
        bus.if_req = 0;
        bus.mem_req = 0;
        #1;
        check_zero("mid_rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        c += 2;
        clear_from(c + 1);
        free_at = c + 1;
        streak_m = 0;
        last_if = 0;
        f_pend = 0; d_pend = 0; f_gnt = 0; d_gnt = 0;
        saw_ifv = 0; saw_memv = 0;
        fq.delete();
        dq.delete();
        run(10);
        dq.push_back('{1'b0, 32'h0000_0040, 32'h0});
        nmv = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.mem_valid) nmv++;
        end
        check("post_rst_valids", nmv, 1);
        check("post_rst_load", bus.mem_rdata, mdl_mem[16]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
